// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: per-request lookup controller for a 4-way set-associative
// L2 tag store. It holds the tag, valid, dirty and LRU state. It resolves hit or
// miss and, on a miss, picks a victim. It writes back a dirty victim, fetches the
// fill, installs the new tag and then responds. Tags and state only; there is no
// data array.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   req_valid/req_ready   request handshake (req_write, req_tag, req_index)
//   resp_valid/resp_ready response handshake (resp_hit, resp_way)
//   mem_req_valid         memory request pending (mem_req_write: 1 = writeback)
//   mem_req_addr          {tag, index} of the memory request
//   mem_ack               one-cycle completion pulse from memory
//   hit_count/miss_count  saturating lookup statistics
//
// Macro CACHE_STATS_EN: when defined, hit_count/miss_count are live 32-bit
// saturating counters; otherwise both ports are tied to zero.

// Equality comparator for one way.
module cache_tag_cmp #(
   parameter int unsigned tagBits = 10
) (
   input  logic [tagBits-1:0] tag_a,
   input  logic [tagBits-1:0] tag_b,
   output logic               match_c
);
   assign match_c = (tag_a == tag_b);
endmodule

module cache_lookup_ctrl #(
   parameter int unsigned tagBits   = 10,
   parameter int unsigned indexBits = 4,
   parameter int unsigned WAYS      = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [tagBits-1:0]            req_tag,
   input  logic [indexBits-1:0]          req_index,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic                          resp_hit,
   output logic [1:0]                    resp_way,
   output logic                          mem_req_valid,
   output logic                          mem_req_write,
   output logic [tagBits+indexBits-1:0]  mem_req_addr,
   input  logic                          mem_ack,
   output logic [31:0]                   hit_count,
   output logic [31:0]                   miss_count
);
   localparam int unsigned SETS    = 1 << indexBits;
   localparam int unsigned wayBits = 2;
   localparam int unsigned ADDR_W  = tagBits + indexBits;

   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, RESPOND} state_t;

   state_t state, state_n;

   // Tag store and per-way state.
   logic [tagBits-1:0] tag_mem   [SETS][WAYS];
   logic [WAYS-1:0]    valid_mem [SETS];
   logic [WAYS-1:0]    dirty_mem [SETS];
   logic [wayBits-1:0] age_mem   [SETS][WAYS];

   // Latched request and chosen victim.
   logic [tagBits-1:0]   lat_tag;
   logic [indexBits-1:0] lat_index;
   logic                 lat_write;
   logic [wayBits-1:0]   vic_way;

   logic [WAYS-1:0]    match_c;
   logic [WAYS-1:0]    hit_vec;
   logic               hit_any;
   logic [wayBits-1:0] hit_way;
   logic               inv_found;
   logic [wayBits-1:0] inv_way;
   logic [wayBits-1:0] lru_way;
   logic [wayBits-1:0] victim;
   logic               accept;
   logic               upd_en;
   logic [wayBits-1:0] upd_way;
   logic [wayBits-1:0] upd_age;
   logic               fill_en;
   logic [ADDR_W-1:0]  addr_n;

   // One comparator per way against the latched request tag.
   for (genvar g = 0; g < WAYS; g++) begin : g_cmp
      cache_tag_cmp #(.tagBits(tagBits)) u_cmp (
         .tag_a   (lat_tag),
         .tag_b   (tag_mem[lat_index][g]),
         .match_c (match_c[g])
      );
   end

   assign hit_vec = valid_mem[lat_index] & match_c;
   assign hit_any = |hit_vec;

   // Hit way and victim: lowest matching way, lowest invalid way, else oldest way.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      hit_way   = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_mem[lat_index][w]) begin
            inv_found = 1'b1;
            inv_way   = wayBits'(w);
         end
         if (hit_vec[w]) hit_way = wayBits'(w);
      end
      for (int w = 0; w < int'(WAYS); w++) begin
         if (age_mem[lat_index][w] == wayBits'(WAYS - 1)) lru_way = wayBits'(w);
      end
      victim = inv_found ? inv_way : lru_way;
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next state and per-cycle actions.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      upd_en  = 1'b0;
      upd_way = '0;
      fill_en = 1'b0;
      addr_n  = '0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_n = COMPARE;
            end
         end
         COMPARE: begin
            if (hit_any) begin
               upd_en  = 1'b1;
               upd_way = hit_way;
               state_n = RESPOND;
            end else if (valid_mem[lat_index][victim] && dirty_mem[lat_index][victim]) begin
               addr_n  = {tag_mem[lat_index][victim], lat_index};
               state_n = WRITEBACK;
            end else begin
               addr_n  = {lat_tag, lat_index};
               state_n = FILL;
            end
         end
         WRITEBACK: begin
            addr_n = mem_req_addr;
            if (mem_ack) begin
               addr_n  = {lat_tag, lat_index};
               state_n = FILL;
            end
         end
         FILL: begin
            addr_n = {lat_tag, lat_index};
            if (mem_ack) begin
               upd_en  = 1'b1;
               upd_way = vic_way;
               fill_en = 1'b1;
               addr_n  = '0;
               state_n = RESPOND;
            end
         end
         RESPOND: begin
            if (resp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign upd_age = age_mem[lat_index][upd_way];

   // Registered outputs and request latch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_hit      <= 1'b0;
         resp_way      <= '0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         lat_tag       <= '0;
         lat_index     <= '0;
         lat_write     <= 1'b0;
         vic_way       <= '0;
      end else begin
         req_ready     <= (state_n == IDLE);
         resp_valid    <= (state_n == RESPOND);
         mem_req_valid <= (state_n == WRITEBACK) || (state_n == FILL);
         mem_req_write <= (state_n == WRITEBACK);
         mem_req_addr  <= addr_n;
         if (accept) begin
            lat_tag   <= req_tag;
            lat_index <= req_index;
            lat_write <= req_write;
         end
         if (state == COMPARE) vic_way <= victim;
         if (state == COMPARE && hit_any) begin
            resp_hit <= 1'b1;
            resp_way <= hit_way;
         end else if (fill_en) begin
            resp_hit <= 1'b0;
            resp_way <= vic_way;
         end
      end
   end

   // Valid, dirty and LRU ages; ages stay a permutation of 0..WAYS-1 per set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < int'(SETS); s++) begin
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
            for (int w = 0; w < int'(WAYS); w++) age_mem[s][w] <= wayBits'(w);
         end
      end else begin
         if (fill_en) begin
            valid_mem[lat_index][vic_way] <= 1'b1;
            dirty_mem[lat_index][vic_way] <= lat_write;
         end else if (upd_en && lat_write) begin
            dirty_mem[lat_index][upd_way] <= 1'b1;
         end
         if (upd_en) begin
            for (int w = 0; w < int'(WAYS); w++) begin
               if (wayBits'(w) == upd_way)
                  age_mem[lat_index][w] <= '0;
               else if (age_mem[lat_index][w] < upd_age)
                  age_mem[lat_index][w] <= age_mem[lat_index][w] + 1'b1;
            end
         end
      end
   end

   // Tag array needs no reset; valid bits qualify every entry.
   always_ff @(posedge clock) begin
      if (fill_en) tag_mem[lat_index][vic_way] <= lat_tag;
   end

`ifdef CACHE_STATS_EN
   // Saturating lookup statistics, counted on the COMPARE cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == COMPARE) begin
         if (hit_any && hit_count != '1)    hit_count  <= hit_count + 32'd1;
         if (!hit_any && miss_count != '1)  miss_count <= miss_count + 32'd1;
      end
   end
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

   // A tag may live in at most one way of a set.
   always_ff @(posedge clock) begin
      if (!reset && state == COMPARE) begin
         multi_hit_chk: assert ($onehot0(hit_vec));
      end
   end

endmodule
